generic_fifo_mn_flow: RTL and testbench

GENERIC_FIFO_MN_FLOW -- requirements
Module: generic_fifo_mn_flow

---
 rtl/generic_fifo_mn_flow.sv | 171 +++++++++++++++++
 tb/tb_generic_fifo_mn_flow.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/generic_fifo_mn_flow.sv
// ---------------------------------------------------------------------------
// generic_fifo_mn_flow
//   Multi-write / multi-read FIFO. Up to NUM_WR lanes push per cycle and are
//   compacted into consecutive slots. Up to NUM_RD entries pop per cycle. The
//   depth need not be a power of two.
//
// Ports
//   i_clk, i_reset     rising-edge clock, synchronous active-high reset
//   i_data, i_psh      per-lane write data / write valid (any lane pattern)
//   o_psh_acc          per-lane accept, combinational, same cycle
//   i_pop_cnt          entries to pop this cycle (0..NUM_RD)
//   o_data, o_rd_vld   lane j = entry at head+j, valid when j < occupancy
//   o_cnt, o_free      occupancy / ENTRIES - occupancy
//   o_full, o_empty, o_afull   status flags from registered occupancy
//   o_ovf, o_udf       sticky overflow / underflow
//   i_flush, i_err_clr discard contents / clear sticky errors
//   o_rdptr, o_wrptr   head / tail index, always 0..ENTRIES-1
// ---------------------------------------------------------------------------
module generic_fifo_mn_flow #(
  parameter int DATA_WIDTH   = 32,
  parameter int ENTRIES      = 12,
  parameter int NUM_WR       = 4,
  parameter int NUM_RD       = 3,
  parameter int AFULL_THRESH = ENTRIES - NUM_WR,
  localparam int ADDR_SIZE   = (ENTRIES == 1) ? 1 : $clog2(ENTRIES),
  localparam int RCW         = $clog2(NUM_RD + 1)
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]   i_data,
  input  logic [NUM_WR-1:0]                   i_psh,
  output logic [NUM_WR-1:0]                   o_psh_acc,
  input  logic [RCW-1:0]                      i_pop_cnt,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0]   o_data,
  output logic [NUM_RD-1:0]                   o_rd_vld,
  output logic [ADDR_SIZE:0]                  o_cnt,
  output logic [ADDR_SIZE:0]                  o_free,
  output logic                                o_full,
  output logic                                o_empty,
  output logic                                o_afull,
  output logic                                o_ovf,
  output logic                                o_udf,
  input  logic                                i_flush,
  input  logic                                i_err_clr,
  output logic [ADDR_SIZE:0]                  o_rdptr,
  output logic [ADDR_SIZE:0]                  o_wrptr
);

  localparam int CW = ADDR_SIZE + 1;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t ENT    = cnt_t'(ENTRIES);
  localparam cnt_t AFULL  = cnt_t'(AFULL_THRESH);
  localparam cnt_t RD_MAX = cnt_t'(NUM_RD);
  localparam cnt_t ONE    = cnt_t'(1);

  // Both operands are below ENTRIES, so the sum is below 2*ENTRIES and one
  // conditional subtraction brings it back into range for any depth.
  function automatic cnt_t wrap(input cnt_t a);
    return (a >= ENT) ? a - ENT : a;
  endfunction

  logic [DATA_WIDTH-1:0] mem [ENTRIES];

  cnt_t rdptr, wrptr, cnt, free;
  logic ovf, udf;

  logic [ADDR_SIZE-1:0] wr_addr [NUM_WR];
  logic [NUM_WR-1:0]    acc;
  cnt_t                 acc_cnt, pop_req, pop_eff;
  logic                 ovf_evt, udf_evt;

  assign free = ENT - cnt;

  // Write compaction. Valid lanes take ranks in lane order; once a rank
  // reaches the free space every later valid lane is rejected too, so the
  // running accept count equals the rank of each accepted lane.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    acc     = '0;
    acc_cnt = '0;
    ovf_evt = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      wr_addr[i] = ADDR_SIZE'(wrap(wrptr + acc_cnt));
      if (i_psh[i]) begin
        if (acc_cnt < free) begin
          acc[i]  = 1'b1;
          acc_cnt = acc_cnt + ONE;
        end else begin
          ovf_evt = 1'b1;
        end
      end
    end
  end

  // Pop request: clamp to the lane count, then to the occupancy. Asking for
  // more than either is an underflow.
  always_comb begin
    pop_req = cnt_t'(i_pop_cnt);
    udf_evt = 1'b0;
    if (pop_req > RD_MAX) begin
      pop_req = RD_MAX;
      udf_evt = 1'b1;
    end
    if (pop_req > cnt) begin
      pop_eff = cnt;
      udf_evt = 1'b1;
    end else begin
      pop_eff = pop_req;
    end
  end

  // Read lanes show registered contents only; a push becomes visible the
  // cycle after it is accepted.
  always_comb begin
    for (int j = 0; j < NUM_RD; j++) begin
      o_rd_vld[j] = cnt_t'(j) < cnt;
      o_data[j]   = o_rd_vld[j] ? mem[ADDR_SIZE'(wrap(rdptr + cnt_t'(j)))]
                                : '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rdptr <= '0;
      wrptr <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (i_flush) begin
        rdptr <= '0;
        wrptr <= '0;
        cnt   <= '0;
      end else begin
        rdptr <= wrap(rdptr + pop_eff);
        wrptr <= wrap(wrptr + acc_cnt);
        cnt   <= cnt + acc_cnt - pop_eff;
      end
      // A fresh error in the clearing cycle keeps the flag set. Pops are
      // ignored during a flush, so they cannot underflow.
      ovf <= ovf_evt | (ovf & ~i_err_clr);
      udf <= (udf_evt & ~i_flush) | (udf & ~i_err_clr);
    end
  end

  // NOTE: storage has no reset; occupancy alone decides which entries are
  // visible, so stale contents can never reach a valid read lane.
  always_ff @(posedge i_clk) begin
    if (!i_reset && !i_flush) begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (acc[i]) mem[wr_addr[i]] <= i_data[i];
      end
    end
  end

  assign o_psh_acc = acc;
  assign o_cnt     = cnt;
  assign o_free    = free;
  assign o_full    = (cnt == ENT);
  assign o_empty   = (cnt == '0);
  assign o_afull   = (cnt >= AFULL);
  assign o_ovf     = ovf;
  assign o_udf     = udf;
  assign o_rdptr   = rdptr;
  assign o_wrptr   = wrptr;

endmodule

// File: tb/tb_generic_fifo_mn_flow.sv
// ---------------------------------------------------------------------------
// tb_generic_fifo_mn_flow
//   Directed vector table on a default-parameter instance (12 deep), then
//   shared random stimulus driven into 12-, 5- and 8-deep instances, each
//   compared every cycle against an ordered-list reference model.
// ---------------------------------------------------------------------------
module tb_generic_fifo_mn_flow;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, flush, clr;
  logic [3:0]        psh;
  logic [3:0][31:0]  din;
  logic [1:0]        pop;

  // instance 0: 12 deep
  logic [3:0] a_acc; logic [2:0][31:0] a_data; logic [2:0] a_vld;
  logic [4:0] a_cnt, a_free, a_rd, a_wr;
  logic a_full, a_empty, a_afull, a_ovf, a_udf;
  // instance 1: 5 deep
  logic [3:0] b_acc; logic [2:0][31:0] b_data; logic [2:0] b_vld;
  logic [3:0] b_cnt, b_free, b_rd, b_wr;
  logic b_full, b_empty, b_afull, b_ovf, b_udf;
  // instance 2: 8 deep
  logic [3:0] c_acc; logic [2:0][31:0] c_data; logic [2:0] c_vld;
  logic [3:0] c_cnt, c_free, c_rd, c_wr;
  logic c_full, c_empty, c_afull, c_ovf, c_udf;

  generic_fifo_mn_flow dut12 (
    .i_clk(clk), .i_reset(rst), .i_data(din), .i_psh(psh), .o_psh_acc(a_acc),
    .i_pop_cnt(pop), .o_data(a_data), .o_rd_vld(a_vld), .o_cnt(a_cnt),
    .o_free(a_free), .o_full(a_full), .o_empty(a_empty), .o_afull(a_afull),
    .o_ovf(a_ovf), .o_udf(a_udf), .i_flush(flush), .i_err_clr(clr),
    .o_rdptr(a_rd), .o_wrptr(a_wr));

  generic_fifo_mn_flow #(.ENTRIES(5)) dut5 (
    .i_clk(clk), .i_reset(rst), .i_data(din), .i_psh(psh), .o_psh_acc(b_acc),
    .i_pop_cnt(pop), .o_data(b_data), .o_rd_vld(b_vld), .o_cnt(b_cnt),
    .o_free(b_free), .o_full(b_full), .o_empty(b_empty), .o_afull(b_afull),
    .o_ovf(b_ovf), .o_udf(b_udf), .i_flush(flush), .i_err_clr(clr),
    .o_rdptr(b_rd), .o_wrptr(b_wr));

  generic_fifo_mn_flow #(.ENTRIES(8)) dut8 (
    .i_clk(clk), .i_reset(rst), .i_data(din), .i_psh(psh), .o_psh_acc(c_acc),
    .i_pop_cnt(pop), .o_data(c_data), .o_rd_vld(c_vld), .o_cnt(c_cnt),
    .o_free(c_free), .o_full(c_full), .o_empty(c_empty), .o_afull(c_afull),
    .o_ovf(c_ovf), .o_udf(c_udf), .i_flush(flush), .i_err_clr(clr),
    .o_rdptr(c_rd), .o_wrptr(c_wr));

  // Observable state per instance, in one fixed packing.
  logic [127:0] act_st  [3];
  logic [3:0]   act_acc [3];
  assign act_st[0] = {14'd0, a_ovf, a_udf, a_full, a_empty, a_afull, a_vld,
                      a_cnt, a_free, a_data};
  assign act_st[1] = {14'd0, b_ovf, b_udf, b_full, b_empty, b_afull, b_vld,
                      1'b0, b_cnt, 1'b0, b_free, b_data};
  assign act_st[2] = {14'd0, c_ovf, c_udf, c_full, c_empty, c_afull, c_vld,
                      1'b0, c_cnt, 1'b0, c_free, c_data};
  assign act_acc[0] = a_acc;
  assign act_acc[1] = b_acc;
  assign act_acc[2] = c_acc;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Recognisable data word for group g, lane i.
  function automatic logic [31:0] mk(input int g, input int i);
    return 32'hC0DE_0000 | 32'(g * 16 + i);
  endfunction

  function automatic logic [3:0][31:0] lanes(input int g);
    logic [3:0][31:0] r;
    for (int i = 0; i < 4; i++) r[i] = mk(g, i);
    return r;
  endfunction

  typedef struct {
    logic             rst, flush, clr;
    logic [3:0]       psh;
    logic [1:0]       pop;
    logic [3:0][31:0] d;
    logic [3:0]       acc;
    int               cnt, rd, wr;
    logic             ovf, udf;
    logic [2:0][31:0] q;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic r, f, c, input logic [3:0] p,
                             input logic [1:0] pc, input int g,
                             input logic [3:0] acc, input int cnt, rd, wr,
                             input logic ovf, udf,
                             input logic [31:0] q0, q1, q2);
    vec_t t;
    t.rst = r; t.flush = f; t.clr = c; t.psh = p; t.pop = pc; t.d = lanes(g);
    t.acc = acc; t.cnt = cnt; t.rd = rd; t.wr = wr; t.ovf = ovf; t.udf = udf;
    t.q = {q2, q1, q0};
    return t;
  endfunction

  // ---------------- reference model (ordered list per instance) ----------
  int          ents [3] = '{12, 5, 8};
  int          afs  [3] = '{8, 1, 4};
  logic [31:0] mq   [3][16];
  int          mc   [3];
  logic        mo   [3];
  logic        mu   [3];

  function automatic logic [3:0] model_acc(input int k);
    logic [3:0] r = '0;
    int rank = 0;
    for (int i = 0; i < 4; i++)
      if (psh[i]) begin
        if (rank < ents[k] - mc[k]) r[i] = 1'b1;
        rank++;
      end
    return r;
  endfunction

  task automatic model_step(input int k);
    logic [3:0] a = model_acc(k);
    logic oe = |(psh & ~a);
    logic ue = 1'b0;
    int eff;
    if (rst) begin
      mc[k] = 0; mo[k] = 1'b0; mu[k] = 1'b0;
    end else begin
      if (flush) begin
        mc[k] = 0;
      end else begin
        ue  = int'(pop) > mc[k];
        eff = ue ? mc[k] : int'(pop);
        for (int j = 0; j < mc[k] - eff; j++) mq[k][j] = mq[k][j + eff];
        mc[k] -= eff;
        for (int i = 0; i < 4; i++)
          if (a[i]) begin mq[k][mc[k]] = din[i]; mc[k]++; end
      end
      mo[k] = oe | (mo[k] & ~clr);
      mu[k] = ue | (mu[k] & ~clr);
    end
  endtask

  function automatic logic [127:0] model_st(input int k);
    logic [2:0]       vld;
    logic [2:0][31:0] q;
    for (int j = 0; j < 3; j++) begin
      vld[j] = j < mc[k];
      q[j]   = vld[j] ? mq[k][j] : 32'd0;
    end
    return {14'd0, mo[k], mu[k], 1'(mc[k] == ents[k]), 1'(mc[k] == 0),
            1'(mc[k] >= afs[k]), vld, 5'(mc[k]), 5'(ents[k] - mc[k]), q};
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; clr = 1'b0; psh = '0; din = '0; pop = '0;

    //          rst flush clr psh      pop g   acc      cnt rd wr ovf udf  q0 q1 q2
    vecs.push_back(v(1, 0, 0, 4'b0000, 0, 0,  4'b0000, 0,  0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 4'b1010, 0, 1,  4'b1010, 2,  0, 2,  0, 0, mk(1,1), mk(1,3), 0));
    vecs.push_back(v(0, 0, 0, 4'b1111, 0, 2,  4'b1111, 6,  0, 6,  0, 0, mk(1,1), mk(1,3), mk(2,0)));
    vecs.push_back(v(0, 0, 0, 4'b1111, 0, 3,  4'b1111, 10, 0, 10, 0, 0, mk(1,1), mk(1,3), mk(2,0)));
    vecs.push_back(v(0, 0, 0, 4'b1111, 0, 4,  4'b0011, 12, 0, 0,  1, 0, mk(1,1), mk(1,3), mk(2,0)));
    vecs.push_back(v(0, 0, 1, 4'b0001, 0, 13, 4'b0000, 12, 0, 0,  1, 0, mk(1,1), mk(1,3), mk(2,0)));
    vecs.push_back(v(0, 0, 1, 4'b0000, 0, 0,  4'b0000, 12, 0, 0,  0, 0, mk(1,1), mk(1,3), mk(2,0)));
    vecs.push_back(v(0, 0, 0, 4'b0000, 3, 0,  4'b0000, 9,  3, 0,  0, 0, mk(2,1), mk(2,2), mk(2,3)));
    vecs.push_back(v(0, 0, 0, 4'b0000, 3, 0,  4'b0000, 6,  6, 0,  0, 0, mk(3,0), mk(3,1), mk(3,2)));
    vecs.push_back(v(0, 0, 0, 4'b0000, 3, 0,  4'b0000, 3,  9, 0,  0, 0, mk(3,3), mk(4,0), mk(4,1)));
    vecs.push_back(v(0, 0, 0, 4'b0000, 1, 0,  4'b0000, 2,  10, 0, 0, 0, mk(4,0), mk(4,1), 0));
    vecs.push_back(v(0, 0, 0, 4'b0000, 3, 0,  4'b0000, 0,  0, 0,  0, 1, 0, 0, 0));
    vecs.push_back(v(0, 0, 1, 4'b0000, 0, 0,  4'b0000, 0,  0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 4'b1111, 0, 5,  4'b1111, 4,  0, 4,  0, 0, mk(5,0), mk(5,1), mk(5,2)));
    vecs.push_back(v(0, 0, 0, 4'b1111, 0, 6,  4'b1111, 8,  0, 8,  0, 0, mk(5,0), mk(5,1), mk(5,2)));
    vecs.push_back(v(0, 0, 0, 4'b0101, 0, 7,  4'b0101, 10, 0, 10, 0, 0, mk(5,0), mk(5,1), mk(5,2)));
    vecs.push_back(v(0, 0, 0, 4'b0000, 3, 0,  4'b0000, 7,  3, 10, 0, 0, mk(5,3), mk(6,0), mk(6,1)));
    vecs.push_back(v(0, 0, 0, 4'b0000, 3, 0,  4'b0000, 4,  6, 10, 0, 0, mk(6,2), mk(6,3), mk(7,0)));
    vecs.push_back(v(0, 0, 0, 4'b0000, 2, 0,  4'b0000, 2,  8, 10, 0, 0, mk(7,0), mk(7,2), 0));
    // wrap across index 11 -> 0 with a same-cycle pop
    vecs.push_back(v(0, 0, 0, 4'b1111, 2, 8,  4'b1111, 4,  10, 2, 0, 0, mk(8,0), mk(8,1), mk(8,2)));
    vecs.push_back(v(0, 0, 1, 4'b0000, 3, 0,  4'b0000, 1,  1, 2,  0, 0, mk(8,3), 0, 0));
    vecs.push_back(v(0, 0, 0, 4'b1111, 0, 9,  4'b1111, 5,  1, 6,  0, 0, mk(8,3), mk(9,0), mk(9,1)));
    // flush with pushes and pops in the same cycle
    vecs.push_back(v(0, 1, 0, 4'b1111, 2, 10, 4'b1111, 0,  0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 4'b0000, 3, 0,  4'b0000, 0,  0, 0,  0, 0, 0, 0, 0));
    // reset mid-operation discards contents
    vecs.push_back(v(0, 0, 0, 4'b1111, 0, 11, 4'b1111, 4,  0, 4,  0, 0, mk(11,0), mk(11,1), mk(11,2)));
    vecs.push_back(v(1, 0, 0, 4'b1111, 1, 12, 4'b1111, 0,  0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 4'b0001, 0, 14, 4'b0001, 1,  0, 1,  0, 0, mk(14,0), 0, 0));

    foreach (vecs[n]) begin
      vec_t t = vecs[n];
      logic [2:0] vld;
      for (int j = 0; j < 3; j++) vld[j] = j < t.cnt;
      @(negedge clk);
      rst = t.rst; flush = t.flush; clr = t.clr; psh = t.psh; pop = t.pop;
      din = t.d;
      #1;
      check($sformatf("v%0d acc", n), 128'(a_acc), 128'(t.acc));
      @(posedge clk);
      #1;
      check($sformatf("v%0d cnt", n),   128'(a_cnt),  128'(t.cnt));
      check($sformatf("v%0d free", n),  128'(a_free), 128'(12 - t.cnt));
      check($sformatf("v%0d flags", n), 128'({a_full, a_empty, a_afull}),
            128'({t.cnt == 12, t.cnt == 0, t.cnt >= 8}));
      check($sformatf("v%0d ptrs", n),  128'({a_rd, a_wr}),
            128'({5'(t.rd), 5'(t.wr)}));
      check($sformatf("v%0d err", n),   128'({a_ovf, a_udf}),
            128'({t.ovf, t.udf}));
      check($sformatf("v%0d vld", n),   128'(a_vld),  128'(vld));
      check($sformatf("v%0d data", n),  128'(a_data), 128'(t.q));
    end

    // Random phase: one reset, then shared stimulus for all three depths.
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      rst   = (c == 0) || ($urandom_range(999) == 0);
      flush = $urandom_range(63) == 0;
      clr   = $urandom_range(15) == 0;
      psh   = ((c / 256) % 2 == 0) ? 4'($urandom & $urandom) : 4'($urandom);
      pop   = 2'($urandom_range(3));
      for (int i = 0; i < 4; i++) din[i] = $urandom;
      #1;
      for (int k = 0; k < 3; k++) begin
        if (c > 0) check($sformatf("r%0d c%0d acc", ents[k], c),
                         128'(act_acc[k]), 128'(model_acc(k)));
        model_step(k);
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++)
        check($sformatf("r%0d c%0d state", ents[k], c), act_st[k], model_st(k));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
